// File: rtl/approx_dot_accum_pkg.sv
// Shared constants, FSM state encoding and width helper for approx_dot_accum.
package approx_dot_accum_pkg;

  localparam int unsigned LENGTH_DEF = 8;
  localparam int unsigned THETA_DEF  = 3;
  localparam int unsigned DEPTH_DEF  = 16;
  localparam int unsigned ACC_W_DEF  = 20;

  typedef logic [1:0] state_t;

  localparam state_t ST_ACC   = 2'd0;
  localparam state_t ST_FLUSH = 2'd1;
  localparam state_t ST_HOLD  = 2'd2;

  // Width needed to count 0..depth terms.
  function automatic int unsigned cnt_width(input int unsigned depth);
    return $clog2(depth + 1);
  endfunction

endpackage

// File: rtl/approx_dot_accum_mult_stage.sv
// ppct_mult_stage: column-truncated multiplier with product register and pending flag.
module ppct_mult_stage
  import approx_dot_accum_pkg::*;
#(
  parameter int unsigned LENGTH = LENGTH_DEF,
  parameter int unsigned THETA  = THETA_DEF
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  load,
  input  logic [LENGTH-1:0]     x,
  input  logic [LENGTH-1:0]     y,
  output logic [2*LENGTH-1:0]   prod,
  output logic                  pend
);

  localparam int unsigned PW = 2 * LENGTH;

  logic [PW-1:0]     prod_c;
  logic [LENGTH-1:0] row;

  // Sum of partial-product rows; the lowest THETA rows lose their low columns.
  always_comb begin
    prod_c = '0;
    row    = '0;
    for (int unsigned i = 0; i < LENGTH; i++) begin
      row = x;
      if (i < THETA) row = (x >> (THETA - i)) << (THETA - i);
      if (y[i]) prod_c = prod_c + (PW'(row) << i);
    end
  end

  // Capture the product of an accepted term; pend marks it for one add.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      prod <= '0;
      pend <= 1'b0;
    end else begin
      pend <= load;
      if (load) prod <= prod_c;
    end
  end

endmodule

// File: rtl/approx_dot_accum.sv
// approx_dot_accum: streams approximate products into a dot-product sum.
// Optional feature macro: APPROX_DOT_SAT_EN (saturating accumulation, sticky out_sat).
module approx_dot_accum
  import approx_dot_accum_pkg::*;
#(
  parameter int unsigned LENGTH = LENGTH_DEF,
  parameter int unsigned THETA  = THETA_DEF,
  parameter int unsigned DEPTH  = DEPTH_DEF,
  parameter int unsigned ACC_W  = ACC_W_DEF
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        in_valid,
  output logic                        in_ready,
  input  logic [LENGTH-1:0]           x,
  input  logic [LENGTH-1:0]           y,
  input  logic                        in_last,
  output logic                        out_valid,
  input  logic                        out_ready,
  output logic [ACC_W-1:0]            out_data,
  output logic [cnt_width(DEPTH)-1:0] out_count,
  output logic                        out_sat
);

  localparam int unsigned CNT_W = cnt_width(DEPTH);

  state_t               state;
  state_t               state_d;
  logic                 accept;
  logic                 last_term;
  logic                 done;
  logic [2*LENGTH-1:0]  prod;
  logic                 pend;
  logic [ACC_W-1:0]     prod_ext;
  logic [ACC_W-1:0]     acc;
  logic [ACC_W-1:0]     acc_next;
  logic [CNT_W-1:0]     count;

  ppct_mult_stage #(
    .LENGTH (LENGTH),
    .THETA  (THETA)
  ) u_mult (
    .clk   (clk),
    .rst_n (rst_n),
    .load  (accept),
    .x     (x),
    .y     (y),
    .prod  (prod),
    .pend  (pend)
  );

  assign prod_ext = ACC_W'(prod);

  // Next-state and handshake decode; ready/valid depend on state only.
  always_comb begin
    state_d   = state;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    accept    = 1'b0;
    last_term = 1'b0;
    done      = 1'b0;
    case (state)
      ST_ACC: begin
        in_ready  = 1'b1;
        accept    = in_valid;
        last_term = in_last || (count == CNT_W'(DEPTH - 1));
        if (accept && last_term) state_d = ST_FLUSH;
      end
      ST_FLUSH: state_d = ST_HOLD;
      ST_HOLD: begin
        out_valid = 1'b1;
        done      = out_ready;
        if (out_ready) state_d = ST_ACC;
      end
      default: state_d = ST_ACC;
    endcase
  end

`ifdef APPROX_DOT_SAT_EN
  logic [ACC_W:0] sum;
  logic           sat;

  // Carry out of the accumulator clamps to all-ones.
  always_comb begin
    sum      = {1'b0, acc} + {1'b0, prod_ext};
    acc_next = sum[ACC_W] ? '1 : sum[ACC_W-1:0];
  end

  // Sticky saturation flag for the current vector.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)             sat <= 1'b0;
    else if (done)          sat <= 1'b0;
    else if (pend && sum[ACC_W]) sat <= 1'b1;
  end

  assign out_sat = sat;
`else
  // Modulo-2^ACC_W accumulation.
  always_comb begin
    acc_next = acc + prod_ext;
  end

  assign out_sat = 1'b0;
`endif

  // State, term counter and accumulator.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= ST_ACC;
      acc   <= '0;
      count <= '0;
    end else begin
      state <= state_d;
      if (done) begin
        acc   <= '0;
        count <= '0;
      end else begin
        if (accept) count <= count + CNT_W'(1);
        if (pend)   acc   <= acc_next;
      end
    end
  end

  assign out_data  = acc;
  assign out_count = count;

endmodule

// File: tb/tb_approx_dot_accum.sv
// Self-checking bench for approx_dot_accum (default ACC_W and an ACC_W=16 instance).
module tb_approx_dot_accum;
  import approx_dot_accum_pkg::*;

  localparam int unsigned CW = cnt_width(DEPTH_DEF);

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          in_valid = 1'b0;
  logic [7:0]    x = '0;
  logic [7:0]    y = '0;
  logic          in_last = 1'b0;
  logic          out_ready;
  logic          dir_ready = 1'b0;
  logic          rnd_ready = 1'b0;
  logic          rand_mode = 1'b0;

  logic          in_ready, out_valid, out_sat;
  logic [19:0]   out_data;
  logic [CW-1:0] out_count;
  logic          in_ready16, out_valid16, out_sat16;
  logic [15:0]   out_data16;
  logic [CW-1:0] out_count16;

  int checks = 0;
  int errors = 0;
  logic cmp_en = 1'b0;

  // model state
  longint prods[$];
  bit     m_ready = 1'b1;
  bit     m_vld = 1'b0;
  bit     m_flush = 1'b0;
  longint m_count = 0;
  longint m_data20 = 0, m_data16 = 0;
  bit     m_sat20 = 1'b0, m_sat16 = 1'b0;

  assign out_ready = rand_mode ? rnd_ready : dir_ready;

  approx_dot_accum dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .x(x), .y(y), .in_last(in_last), .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .out_count(out_count), .out_sat(out_sat)
  );

  approx_dot_accum #(.ACC_W(16)) dut16 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready16),
    .x(x), .y(y), .in_last(in_last), .out_valid(out_valid16), .out_ready(out_ready),
    .out_data(out_data16), .out_count(out_count16), .out_sat(out_sat16)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Approximate product straight from the row definition.
  function automatic longint approx(input logic [7:0] a, input logic [7:0] b);
    longint s = 0;
    for (int i = 0; i < int'(LENGTH_DEF); i++) begin
      if (b[i]) begin
        longint r = longint'(a);
        if (i < int'(THETA_DEF)) r = (r >> (int'(THETA_DEF) - i)) << (int'(THETA_DEF) - i);
        s += r << i;
      end
    end
    return s;
  endfunction

  // Fold the vector's products into a w-bit accumulator.
  function automatic void fold(input int w, output longint data, output bit sat);
    longint mask = (longint'(1) << w) - 1;
    data = 0;
    sat  = 1'b0;
    foreach (prods[k]) begin
      data += prods[k] & mask;
      if (data > mask) begin
`ifdef APPROX_DOT_SAT_EN
        data = mask;
        sat  = 1'b1;
`else
        data &= mask;
`endif
      end
    end
  endfunction

  // Transaction-level reference model, advanced on each rising edge.
  initial forever begin
    @(posedge clk or negedge rst_n);
    if (!rst_n) begin
      m_ready = 1'b1; m_vld = 1'b0; m_flush = 1'b0; prods.delete();
    end else if (m_vld) begin
      if (out_ready) begin
        m_vld = 1'b0; m_ready = 1'b1; prods.delete();
      end
    end else if (m_flush) begin
      m_flush = 1'b0;
      m_vld   = 1'b1;
      m_count = longint'(prods.size());
      fold(int'(ACC_W_DEF), m_data20, m_sat20);
      fold(16, m_data16, m_sat16);
    end else if (m_ready && in_valid) begin
      prods.push_back(approx(x, y));
      if (in_last || prods.size() == int'(DEPTH_DEF)) begin
        m_ready = 1'b0; m_flush = 1'b1;
      end
    end
  end

  // Cycle-by-cycle comparison against the model.
  initial forever begin
    @(negedge clk);
    if (rst_n && cmp_en) begin
      chk("in_ready", 64'(in_ready), 64'(m_ready));
      chk("out_valid", 64'(out_valid), 64'(m_vld));
      chk("in_ready16", 64'(in_ready16), 64'(m_ready));
      chk("out_valid16", 64'(out_valid16), 64'(m_vld));
      if (m_vld) begin
        chk("out_data", 64'(out_data), 64'(m_data20));
        chk("out_count", 64'(out_count), 64'(m_count));
        chk("out_sat", 64'(out_sat), 64'(m_sat20));
        chk("out_data16", 64'(out_data16), 64'(m_data16));
        chk("out_count16", 64'(out_count16), 64'(m_count));
        chk("out_sat16", 64'(out_sat16), 64'(m_sat16));
      end
    end
  end

  initial forever begin
    @(negedge clk);
    rnd_ready = ($urandom_range(0, 3) != 0);
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  // Present one term and return at the falling edge after it is taken.
  task automatic send(input logic [7:0] a, input logic [7:0] b, input logic last);
    int n = 0;
    in_valid = 1'b1; x = a; y = b; in_last = last;
    while (in_ready !== 1'b1 && n < 60) begin
      @(negedge clk);
      n++;
    end
    if (in_ready !== 1'b1) begin
      checks++; errors++;
      $display("FAIL send_timeout: in_ready got %b expected 1", in_ready);
    end
    @(negedge clk);
  endtask

  task automatic idle();
    in_valid = 1'b0; in_last = 1'b0;
  endtask

  task automatic wait_valid();
    int n = 0;
    while (out_valid !== 1'b1 && n < 60) begin
      @(negedge clk);
      n++;
    end
    if (out_valid !== 1'b1) begin
      checks++; errors++;
      $display("FAIL valid_timeout: out_valid got %b expected 1", out_valid);
    end
  endtask

  task automatic handshake();
    dir_ready = 1'b1;
    @(negedge clk);
    dir_ready = 1'b0;
    chk("hs_in_ready", 64'(in_ready), 64'd1);
    chk("hs_out_valid", 64'(out_valid), 64'd0);
  endtask

  initial begin
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    cmp_en = 1'b1;
    chk("rst_in_ready", 64'(in_ready), 64'd1);
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_out_data", 64'(out_data), 64'd0);
    chk("rst_out_count", 64'(out_count), 64'd0);
    chk("rst_out_sat", 64'(out_sat), 64'd0);

    // single term
    send(8'hFF, 8'h01, 1'b1);
    idle();
    chk("single_flush_valid", 64'(out_valid), 64'd0);
    chk("single_flush_ready", 64'(in_ready), 64'd0);
    @(negedge clk);
    chk("single_valid", 64'(out_valid), 64'd1);
    chk("single_data", 64'(out_data), 64'd248);
    chk("single_count", 64'(out_count), 64'd1);
    handshake();

    // four back-to-back terms, then backpressure
    for (int i = 0; i < 4; i++) begin
      chk("b2b_in_ready", 64'(in_ready), 64'd1);
      send(8'hFF, 8'hFF, i == 3);
    end
    idle();
    wait_valid();
    for (int i = 0; i < 5; i++) begin
      chk("bp_valid", 64'(out_valid), 64'd1);
      chk("bp_data", 64'(out_data), 64'd260032);
      chk("bp_count", 64'(out_count), 64'd4);
      chk("bp_in_ready", 64'(in_ready), 64'd0);
      @(negedge clk);
    end
    handshake();

    // forced end at DEPTH
    for (int i = 0; i < 16; i++) send(8'h01, 8'h08, 1'b0);
    idle();
    chk("forced_in_ready", 64'(in_ready), 64'd0);
    wait_valid();
    chk("forced_data", 64'(out_data), 64'd128);
    chk("forced_count", 64'(out_count), 64'd16);
    handshake();
    send(8'h01, 8'h01, 1'b1);
    idle();
    wait_valid();
    chk("trunc_data", 64'(out_data), 64'd0);
    chk("trunc_count", 64'(out_count), 64'd1);
    handshake();

    // narrow accumulator overflow
    send(8'hFF, 8'hFF, 1'b0);
    send(8'hFF, 8'hFF, 1'b1);
    idle();
    wait_valid();
    chk("two_data20", 64'(out_data), 64'd130016);
`ifdef APPROX_DOT_SAT_EN
    chk("ovf_data16", 64'(out_data16), 64'd65535);
    chk("ovf_sat16", 64'(out_sat16), 64'd1);
`else
    chk("ovf_data16", 64'(out_data16), 64'd64480);
    chk("ovf_sat16", 64'(out_sat16), 64'd0);
`endif
    handshake();

    // reset mid-vector
    for (int i = 0; i < 3; i++) send(8'($urandom), 8'($urandom), 1'b0);
    idle();
    rst_n = 1'b0;
    #1;
    chk("mid_rst_in_ready", 64'(in_ready), 64'd1);
    chk("mid_rst_out_valid", 64'(out_valid), 64'd0);
    chk("mid_rst_out_data", 64'(out_data), 64'd0);
    chk("mid_rst_out_count", 64'(out_count), 64'd0);
    chk("mid_rst_out_sat", 64'(out_sat), 64'd0);
    chk("mid_rst_out_data16", 64'(out_data16), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    send(8'h10, 8'h10, 1'b1);
    idle();
    wait_valid();
    chk("post_rst_data", 64'(out_data), 64'd256);
    chk("post_rst_count", 64'(out_count), 64'd1);
    handshake();

    // randomized vectors with gaps and random output backpressure
    rand_mode = 1'b1;
    for (int v = 0; v < 40; v++) begin
      int len = int'($urandom_range(1, 20));
      for (int t = 0; t < len; t++) begin
        if ($urandom_range(0, 3) == 0) begin
          idle();
          repeat ($urandom_range(1, 2)) @(negedge clk);
        end
        send(8'($urandom), 8'($urandom), t == len - 1);
      end
      idle();
    end
    rand_mode = 1'b0;
    dir_ready = 1'b1;
    repeat (40) @(negedge clk);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
